// File: rtl/typed_fifo.sv
// typed_fifo -- synchronous valid/ready FIFO with a type-parameterised payload.
//
// Parameters:
//   T            element type (any packed type), default bit [7:0]
//   DEPTH        number of storage entries (>= 1, any value)
//   FALL_THROUGH 1 = an element offered to an empty FIFO is presented on the
//                output in the same cycle; 0 = registered, one-cycle latency
//
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   in_valid/in_ready    producer handshake, in_data is the element offered
//   out_valid/out_ready  consumer handshake, out_data is the head element
//   count                occupancy, only when TYPED_FIFO_COUNT_EN is defined
//
// Optional feature macro: TYPED_FIFO_COUNT_EN (adds the count output port).
module typed_fifo #(
   parameter type T            = bit [7:0],
   parameter int  DEPTH        = 4,
   parameter bit  FALL_THROUGH = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic in_valid,
   output logic in_ready,
   input  T     in_data,
   output logic out_valid,
   input  logic out_ready,
   output T     out_data
`ifdef TYPED_FIFO_COUNT_EN
   ,
   output logic [$clog2(DEPTH+1)-1:0] count
`endif
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0] OCC_FULL = CW'(DEPTH);
   localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

   T              mem [DEPTH];
   logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
   logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
   logic [CW-1:0] occ_reg, occ_next;
   logic          empty, full, bypass, push, pop;
   T              head;

   assign empty    = (occ_reg == '0);
   assign full     = (occ_reg == OCC_FULL);
   // Depends only on registered occupancy: no push-on-pop when full.
   assign in_ready = !full;

   // Head read as an explicit compare-mux so non-power-of-two depths never
   // index past the array.
   always_comb begin
      head = mem[0];
      for (int i = 0; i < DEPTH; i++) begin
         if (rd_ptr_reg == PW'(i)) head = mem[i];
      end
   end

   generate
      if (FALL_THROUGH) begin : g_ft
         // Empty FIFO forwards the producer straight to the consumer; if the
         // consumer takes it, storage is never touched.
         assign out_valid = empty ? in_valid : 1'b1;
         assign out_data  = empty ? in_data : head;
         assign bypass    = empty & in_valid & out_ready;
      end else begin : g_reg
         assign out_valid = !empty;
         assign out_data  = head;
         assign bypass    = 1'b0;
      end
   endgenerate

   assign push = in_valid & in_ready & ~bypass;
   assign pop  = out_valid & out_ready & ~bypass;

   always_comb begin
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      occ_next    = occ_reg;
      if (push) wr_ptr_next = (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_next = (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + PW'(1);
      if (push && !pop) occ_next = occ_reg + CW'(1);
      else if (pop && !push) occ_next = occ_reg - CW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         occ_reg    <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         occ_reg    <= occ_next;
      end
   end

   // Storage is cleared on reset so out_data reads '0 until first written.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (rst) mem[i] <= '0;
         else if (push && wr_ptr_reg == PW'(i)) mem[i] <= in_data;
      end
   end

`ifdef TYPED_FIFO_COUNT_EN
   assign count = occ_reg;
`endif

endmodule

// File: tb/tb_typed_fifo.sv
// tb_typed_fifo -- exercises four typed_fifo specialisations side by side
// (8-bit depth 4, 16-bit depth 3, 8-bit fall-through depth 2, 1-bit depth 1)
// against a queue-based reference model, directed cases then random traffic.
module tb_typed_fifo;
   localparam int N = 4;

   int dep [N] = '{4, 3, 2, 1};
   bit ft  [N] = '{1'b0, 1'b0, 1'b1, 1'b0};
   int wid [N] = '{8, 16, 8, 1};

   logic        clk = 1'b0;
   logic        rst;
   logic        iv   [N];
   logic        ordy [N];
   logic [15:0] din  [N];
   logic        ir_a [N];
   logic        ov_a [N];
   logic [15:0] od_a [N];

   logic ir0, ir1, ir2, ir3, ov0, ov1, ov2, ov3;
   logic [7:0]  od0;
   logic [15:0] od1;
   logic [7:0]  od2;
   logic        od3;

   int          vec_count = 0;
   int          err_count = 0;
   int unsigned q [N][$];
   bit          clean [N];

   always #5 clk = ~clk;

`ifdef TYPED_FIFO_COUNT_EN
   logic [2:0] c0;
   logic [1:0] c1;
   logic [1:0] c2;
   logic [0:0] c3;
   int         cnt_a [N];
   always_comb begin
      cnt_a[0] = int'(c0);
      cnt_a[1] = int'(c1);
      cnt_a[2] = int'(c2);
      cnt_a[3] = int'(c3);
   end
`endif

   typed_fifo #(.T(bit [7:0]), .DEPTH(4), .FALL_THROUGH(1'b0)) u0 (
      .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir0), .in_data(din[0][7:0]),
      .out_valid(ov0), .out_ready(ordy[0]), .out_data(od0)
`ifdef TYPED_FIFO_COUNT_EN
      , .count(c0)
`endif
   );
   typed_fifo #(.T(bit [15:0]), .DEPTH(3), .FALL_THROUGH(1'b0)) u1 (
      .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir1), .in_data(din[1]),
      .out_valid(ov1), .out_ready(ordy[1]), .out_data(od1)
`ifdef TYPED_FIFO_COUNT_EN
      , .count(c1)
`endif
   );
   typed_fifo #(.T(bit [7:0]), .DEPTH(2), .FALL_THROUGH(1'b1)) u2 (
      .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir2), .in_data(din[2][7:0]),
      .out_valid(ov2), .out_ready(ordy[2]), .out_data(od2)
`ifdef TYPED_FIFO_COUNT_EN
      , .count(c2)
`endif
   );
   typed_fifo #(.T(bit), .DEPTH(1), .FALL_THROUGH(1'b0)) u3 (
      .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir3), .in_data(din[3][0]),
      .out_valid(ov3), .out_ready(ordy[3]), .out_data(od3)
`ifdef TYPED_FIFO_COUNT_EN
      , .count(c3)
`endif
   );

   always_comb begin
      ir_a[0] = ir0; ir_a[1] = ir1; ir_a[2] = ir2; ir_a[3] = ir3;
      ov_a[0] = ov0; ov_a[1] = ov1; ov_a[2] = ov2; ov_a[3] = ov3;
      od_a[0] = {8'h00, od0};
      od_a[1] = od1;
      od_a[2] = {8'h00, od2};
      od_a[3] = {15'h0000, od3};
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_count++;
      if (obs !== exp) begin
         err_count++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int unsigned mask(input int k);
      return (32'd1 << wid[k]) - 32'd1;
   endfunction

   task automatic idle();
      for (int k = 0; k < N; k++) begin
         iv[k]   = 1'b0;
         ordy[k] = 1'b0;
         din[k]  = 16'h0000;
      end
   endtask

   // Inputs are already set (clock low). Compare against the model, then
   // advance the model by the handshakes that happen at the coming edge.
   task automatic step(input bit verbose);
      int unsigned n, exp_od;
      bit          exp_ov, exp_ir, byp, pu, po, chk_od;
      #1;
      for (int k = 0; k < N; k++) begin
         n      = q[k].size();
         exp_ir = (n != dep[k]);
         chk_od = 1'b1;
         if (ft[k] && n == 0) begin
            exp_ov = iv[k];
            exp_od = din[k] & mask(k);
         end else if (n != 0) begin
            exp_ov = 1'b1;
            exp_od = q[k][0];
         end else begin
            exp_ov = 1'b0;
            exp_od = 0;
            chk_od = clean[k];
         end
         check($sformatf("u%0d in_ready", k), 32'(ir_a[k]), 32'(exp_ir));
         check($sformatf("u%0d out_valid", k), 32'(ov_a[k]), 32'(exp_ov));
         if (chk_od) check($sformatf("u%0d out_data", k), 32'(od_a[k]), exp_od);
`ifdef TYPED_FIFO_COUNT_EN
         check($sformatf("u%0d count", k), cnt_a[k], n);
`endif
         if (rst) begin
            q[k].delete();
            clean[k] = 1'b1;
         end else begin
            byp = ft[k] && n == 0 && iv[k] && ordy[k];
            po  = exp_ov && ordy[k] && !byp;
            pu  = iv[k] && exp_ir && !byp;
            if (verbose && (po || byp)) $display("u%0d pop %0h", k, exp_od);
            if (verbose && pu) $display("u%0d push %0h", k, din[k] & mask(k));
            if (po) void'(q[k].pop_front());
            if (pu) begin
               q[k].push_back(din[k] & mask(k));
               clean[k] = 1'b0;
            end
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      idle();
      for (int k = 0; k < N; k++) clean[k] = 1'b1;
      @(negedge clk);
      step(1'b0);
      step(1'b0);
      rst = 1'b0;
      step(1'b0);                          // idle after reset

      // Fill depth-4 FIFO, offer a fifth, then drain in order.
      for (int i = 1; i <= 5; i++) begin
         iv[0]  = 1'b1;
         din[0] = 16'(i * 8'h11);
         step(1'b1);
      end
      iv[0]   = 1'b0;
      ordy[0] = 1'b1;
      repeat (5) step(1'b1);
      idle();

      // Depth-3 continuous streaming with pointer wrap.
      for (int i = 0; i < 10; i++) begin
         iv[1]   = 1'b1;
         ordy[1] = 1'b1;
         din[1]  = 16'(i);
         step(1'b1);
      end
      iv[1] = 1'b0;
      repeat (2) step(1'b1);
      idle();

      // Fall-through bypass on an empty FIFO.
      iv[2]   = 1'b1;
      ordy[2] = 1'b1;
      din[2]  = 16'h00A5;
      step(1'b1);
      idle();
      step(1'b1);

      // Depth-1: push, then reset during an attempted pop.
      iv[3]  = 1'b1;
      din[3] = 16'h0001;
      step(1'b1);
      iv[3]   = 1'b0;
      ordy[3] = 1'b1;
      rst     = 1'b1;
      step(1'b1);
      rst = 1'b0;
      idle();
      step(1'b1);

      // Random traffic with occasional mid-transfer reset.
      for (int c = 0; c < 3000; c++) begin
         for (int k = 0; k < N; k++) begin
            iv[k]   = ($urandom_range(0, 99) < 60);
            ordy[k] = ($urandom_range(0, 99) < 50);
            din[k]  = 16'($urandom);
         end
         rst = ($urandom_range(0, 299) == 0);
         step(1'b0);
      end
      rst = 1'b0;
      idle();
      step(1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
      $finish;
   end
endmodule
